// File: rtl/lif_pkg.sv
// Shared definitions for the LIF layer stage: default widths, leak limits,
// the signed saturation helper and the output beat record.
package lif_pkg;

  localparam int LIF_DATA_W_DEF    = 20;
  localparam int LIF_TAU_SHIFT_DEF = 1;
  localparam int LIF_TAU_SHIFT_MAX = 4;

  // Widest membrane the helpers and the beat record can carry
  localparam int LIF_MAX_W      = 48;
  localparam int LIF_MAX_ADDR_W = 16;

  // One output beat, sized for the widest supported configuration
  typedef struct packed {
    logic                        spike;
    logic signed [LIF_MAX_W-1:0] mem;
    logic [LIF_MAX_ADDR_W-1:0]   neuron;
    logic                        last_neuron;
    logic                        last_step;
  } beat_t;

  // Clamp a sign-extended (w+1)-bit value into the signed range of w bits
  function automatic logic signed [LIF_MAX_W-1:0] sat_dw(
    input logic signed [LIF_MAX_W:0] x,
    input int                        w
  );
    logic signed [LIF_MAX_W:0] one;
    logic signed [LIF_MAX_W:0] hi;
    logic signed [LIF_MAX_W:0] lo;
    one = {{LIF_MAX_W{1'b0}}, 1'b1};
    hi  = (one <<< (w - 1)) - one;
    lo  = ~hi;
    if (x > hi) begin
      sat_dw = hi[LIF_MAX_W-1:0];
    end else if (x < lo) begin
      sat_dw = lo[LIF_MAX_W-1:0];
    end else begin
      sat_dw = x[LIF_MAX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/lif_mem_ram.sv
// Simple dual-port membrane store: one write port, one registered read port.
// Reads and writes to the same address in one cycle never happen here, so
// no write-first bypass is provided.
module lif_mem_ram
  import lif_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = LIF_DATA_W_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the updated membrane of the beat leaving stage 1
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: data only moves on an issued read so it holds across stalls
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lif_array.sv
// Multi-neuron, multi-time-step LIF stage with valid/ready flow control.
// Two pipeline stages: S1 issues the membrane read and holds the input,
// S2 leaks, saturates, fires, writes back and presents the output beat.
// Build option: define LIF_SOFT_RESET_EN to subtract the threshold on a
// spike instead of clearing the membrane to zero.
module lif_array
  import lif_pkg::*;
#(
  parameter int DATA_W     = LIF_DATA_W_DEF,
  parameter int NEURONS    = 64,
  parameter int TIME_STEPS = 4,
  parameter int TAU_SHIFT  = LIF_TAU_SHIFT_DEF,
  localparam int ADDR_W = $clog2(NEURONS)
) (
  input  logic                     s_clk,
  input  logic                     s_rst_n,
  input  logic signed [DATA_W-1:0] THRESHOLD,
  input  logic                     i_clear,
  input  logic signed [DATA_W-1:0] s_delta,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     o_spike,
  output logic signed [DATA_W-1:0] o_mem,
  output logic [ADDR_W-1:0]        o_neuron,
  output logic                     o_last_neuron,
  output logic                     o_last_step,
  output logic                     o_valid,
  input  logic                     i_ready
);

  localparam int T_W   = (TIME_STEPS > 1) ? $clog2(TIME_STEPS) : 1;
  localparam int SHIFT = (TAU_SHIFT > LIF_TAU_SHIFT_MAX) ? LIF_TAU_SHIFT_MAX : TAU_SHIFT;
  localparam int EXT_W = LIF_MAX_W + 1;
  localparam logic [ADDR_W-1:0] LAST_N = ADDR_W'(NEURONS - 1);
  localparam logic [T_W-1:0]    LAST_T = T_W'(TIME_STEPS - 1);

  logic                     adv;
  logic                     accept;
  logic                     wr_en;
  logic [ADDR_W-1:0]        n_cnt;
  logic [T_W-1:0]           t_cnt;
  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_delta;
  logic [ADDR_W-1:0]        s1_n;
  logic [T_W-1:0]           s1_t;
  logic signed [DATA_W-1:0] rd_data;
  logic signed [DATA_W-1:0] pre;
  logic signed [DATA_W:0]   sum;
  logic signed [DATA_W:0]   shifted;
  logic signed [DATA_W-1:0] v;
  logic signed [DATA_W-1:0] stored;
  logic                     spike;

  assign adv     = ~o_valid | i_ready;
  assign s_ready = adv & ~i_clear;
  assign accept  = s_valid & s_ready;
  assign wr_en   = s1_valid & adv & ~i_clear;

  // Implicit neuron / time-step indexing, advanced only by accepted inputs
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      n_cnt <= '0;
      t_cnt <= '0;
    end else if (i_clear) begin
      n_cnt <= '0;
      t_cnt <= '0;
    end else if (accept) begin
      if (n_cnt == LAST_N) begin
        n_cnt <= '0;
        t_cnt <= (t_cnt == LAST_T) ? '0 : t_cnt + 1'b1;
      end else begin
        n_cnt <= n_cnt + 1'b1;
      end
    end
  end

  // Stage 1: capture the accepted increment alongside its neuron and step
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      s1_valid <= 1'b0;
      s1_delta <= '0;
      s1_n     <= '0;
      s1_t     <= '0;
    end else if (i_clear) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_delta <= s_delta;
        s1_n     <= n_cnt;
        s1_t     <= t_cnt;
      end
    end
  end

  // Stage 2 datapath: integrate, leak, saturate, fire and pick the new membrane
  always_comb begin
    pre     = (s1_t == '0) ? '0 : rd_data;
    sum     = (DATA_W+1)'(pre) + (DATA_W+1)'(s1_delta);
    shifted = sum >>> SHIFT;
    v       = DATA_W'(sat_dw(EXT_W'(shifted), DATA_W));
    spike   = (v >= THRESHOLD);
`ifdef LIF_SOFT_RESET_EN
    stored  = spike ? (v - THRESHOLD) : v;
`else
    stored  = spike ? '0 : v;
`endif
  end

  // Stage 2 register: present the beat and hold it while downstream stalls
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      o_valid       <= 1'b0;
      o_spike       <= 1'b0;
      o_mem         <= '0;
      o_neuron      <= '0;
      o_last_neuron <= 1'b0;
      o_last_step   <= 1'b0;
    end else if (i_clear) begin
      o_valid <= 1'b0;
    end else if (adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_spike       <= spike;
        o_mem         <= stored;
        o_neuron      <= s1_n;
        o_last_neuron <= (s1_n == LAST_N);
        o_last_step   <= (s1_t == LAST_T);
      end
    end
  end

  lif_mem_ram #(
    .DEPTH (NEURONS),
    .WIDTH (DATA_W)
  ) u_ram (
    .clk     (s_clk),
    .wr_en   (wr_en),
    .wr_addr (s1_n),
    .wr_data (stored),
    .rd_en   (accept),
    .rd_addr (n_cnt),
    .rd_data (rd_data)
  );

endmodule

// File: doc/lif_array.md
Name: lif_array

Overview:
- Multi-neuron, multi-time-step LIF layer stage for the spiking transformer datapath.
- Consumes a stream of membrane increments (one per neuron per time step), keeps each neuron's membrane in internal RAM across time steps, and emits one spike per input.
- Generalises single-neuron proj LIF with:
  - configurable width, neuron count, time steps and leak shift;
  - valid/ready backpressure;
  - internal state storage.

Parameters:
- DATA_W, 20: membrane/increment width, signed two's complement.
- NEURONS, 64: neurons per time step; must be >= 4.
- TIME_STEPS, 4: time steps per sample; must be >= 1.
- TAU_SHIFT, 1: leak, where 1/tau = 2^-TAU_SHIFT; range 0..4.
- ADDR_W, $clog2(NEURONS): derived local parameter, not overridable.

Ports:
- s_clk, in, 1: single clock.
- s_rst_n, in, 1: asynchronous, active-low reset.
- THRESHOLD, in, DATA_W: signed firing threshold; must be > 0 and static during a sample.
- i_clear, in, 1: synchronous sample restart.
- s_delta, in, DATA_W: signed increment X[t].
- s_valid, in, 1: s_delta valid.
- s_ready, out, 1: block can accept s_delta.
- o_spike, out, 1: spike for the current output beat.
- o_mem, out, DATA_W: post-update stored membrane.
- o_neuron, out, ADDR_W: neuron index of the output beat.
- o_last_neuron, out, 1: beat is neuron NEURONS-1.
- o_last_step, out, 1: beat is in time step TIME_STEPS-1.
- o_valid, out, 1: output beat valid.
- i_ready, in, 1: downstream accepts the beat.

Behaviour:
- Reset (s_rst_n=0, async): all outputs 0, counters 0, pipeline empty. RAM contents are don't-care, because step 0 never reads RAM. A reset mid-sample aborts it; the next input is neuron 0, step 0.
- Handshake:
  - Input transfers when s_valid && s_ready; output transfers when o_valid && i_ready.
  - adv = ~o_valid | i_ready.
  - s_ready = adv & ~i_clear.
  - When adv=0 every stage holds.
  - o_* stay stable while o_valid && !i_ready.
- Indexing: implicit. An input-side neuron counter n counts 0..NEURONS-1 and wraps. On each wrap, step counter t increments, wrapping at TIME_STEPS-1 back to 0.
- Pipeline, 2 stages, latency 2 cycles from the accepted input to o_valid (without stall):
  - S1 issues the RAM read at address n and registers delta, n and t.
  - S2 computes, writes RAM and registers the outputs.
- Arithmetic:
  - pre = (t==0) ? 0 : RAM[n].
  - sum = pre + delta in DATA_W+1 bits.
  - v = sum >>> TAU_SHIFT (arithmetic, floor).
  - v saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Spike when v >= THRESHOLD (signed compare). A negative v never spikes.
  - Stored value is 0 on spike (V_reset=0), else v. o_mem equals the stored value.
- RAW hazard: NEURONS >= 4 guarantees no same-address read during a pending write. A write and a read in the same cycle to different addresses are allowed.
- i_clear:
  - Counters go to 0 next cycle.
  - Both pipeline stages flush: o_valid=0 next cycle and in-flight beats are dropped without RAM write.
  - Any input presented that cycle is not accepted (s_ready=0).
  - i_clear wins over a simultaneous handshake.
- Bubbles: s_valid gaps insert bubbles. Counters only advance on accepted inputs.

Optional Feature:
- Macro LIF_SOFT_RESET_EN.
- Defined: on spike, stored value = v - THRESHOLD (soft reset). o_mem reflects this value.
- Undefined: hard reset to 0 as above. Spike rule, latency and ports are identical in both builds.

Decomposition:
- Package lif_pkg holds:
  - default DATA_W, TAU_SHIFT limits;
  - the signed saturate function sat_dw(DATA_W+1 -> DATA_W);
  - the beat record type (spike, mem, neuron, last_neuron, last_step).
- Sub-module lif_mem_ram: simple dual-port RAM, NEURONS x DATA_W, 1-cycle registered read, write-first not required. The top instantiates it once; counters, pipeline and arithmetic stay in lif_array.

Test Plan:
All cases use DATA_W=20, TAU_SHIFT=1, THRESHOLD=256, NEURONS=4, TIME_STEPS=3 unless stated.
1. Neuron 0, deltas 200, 400, 300 over t=0..2 -> v=100 (no spike, mem 100), v=250 (no spike, mem 250), v=275 (spike, mem 0). Under LIF_SOFT_RESET_EN the last beat gives mem 19.
2. Delta -7 at t=0 -> v=-4, o_spike=0, o_mem=-4. Next step delta 0 -> v=-2.
3. Stream 13 inputs, i_ready=1 -> 13 beats, o_neuron 0,1,2,3 repeating. o_last_neuron on beats 4, 8, 12; o_last_step on beats 9-12. Beat 13 uses pre=0 (new sample).
4. Continuous s_valid while i_ready is held low for 5 cycles mid-stream -> s_ready=0 during the stall, o_* stable, no beat lost or duplicated, order and values match the model.
5. TAU_SHIFT=0, deltas 2^19-1 at t=0 and t=1 with THRESHOLD=2^19-1 -> t0 spikes and stores 0. Repeat with THRESHOLD larger than reachable using a negative-max stream -> saturates at -2^19, no wrap.
6. Pulse i_clear with 2 beats in flight, then pulse s_rst_n low mid-stream -> in-flight beats vanish, o_valid=0, next input reported as neuron 0 with pre=0, all outputs 0 during reset.
